mem_responder: RTL and testbench

//  Memory-side counterpart of the pipelined CPU's instruction/data ports: a 512x16 RAM.

---
 rtl/mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: the RAM behind the pipelined CPU's instruction and data ports.
// It boots the CPU from a host load stream, serves fetches, loads and stores
// while the CPU runs, and streams a memory window back to the host once the
// CPU halts.
module mem_responder #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int DUMP_START = 0,
    parameter int DUMP_COUNT = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [DW-1:0] host_data,
    input  logic          host_last,
    output logic          cpu_reset,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_next,
    input  logic [AW-1:0] data_addr,
    input  logic          mem_write,
    input  logic [DW-1:0] mem_data_in,
    output logic [DW-1:0] mem_data_out,
    input  logic          halt,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          dump_last
);

    localparam int DEPTH = 1 << AW;
    // The dump counter must be able to hold DUMP_COUNT itself.
    localparam int CW = (DUMP_COUNT < 1) ? 1 : $clog2(DUMP_COUNT + 1);
    localparam logic [AW-1:0] START_A = AW'(DUMP_START % DEPTH);

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_BOOT = 3'd1,
        ST_RUN  = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [AW:0]   load_ptr_r;
    logic [CW-1:0] dump_idx_r;
    logic [DW-1:0] mem_r [DEPTH];

    logic          host_ready_r;
    logic          cpu_reset_r;
    logic          dump_valid_r;
    logic [AW-1:0] dump_addr_r;
    logic [DW-1:0] dump_data_r;
    logic          dump_last_r;

    logic          load_hs_s;
    logic          load_end_s;
    logic          store_s;
    logic          dump_hs_s;
    logic          dump_present_s;
    logic          dump_is_last_s;
    logic [AW-1:0] dump_next_addr_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [DW-1:0] mem_wdata_s;

    assign host_ready = host_ready_r;
    assign cpu_reset  = cpu_reset_r;
    assign dump_valid = dump_valid_r;
    assign dump_addr  = dump_addr_r;
    assign dump_data  = dump_data_r;
    assign dump_last  = dump_last_r;

    // Both CPU read ports are plain asynchronous array reads.
    assign inst_next    = mem_r[inst_addr];
    assign mem_data_out = mem_r[data_addr];

    // Handshake and sequencing qualifiers shared by the FSM and the datapath.
    always_comb begin
        load_hs_s        = (state_r == ST_LOAD) && host_valid && host_ready_r;
        load_end_s       = load_hs_s && (host_last || (load_ptr_r == (AW+1)'(DEPTH - 1)));
        store_s          = (state_r == ST_RUN) && mem_write;
        dump_hs_s        = (state_r == ST_DUMP) && dump_valid_r && dump_ready;
        dump_present_s   = (state_r == ST_DUMP) && (!dump_valid_r || (dump_ready && !dump_last_r));
        dump_is_last_s   = (dump_idx_r == CW'(DUMP_COUNT - 1));
        dump_next_addr_s = START_A + AW'(dump_idx_r);
    end

    // Next-state logic for the LOAD -> BOOT -> RUN -> DUMP -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_end_s) begin
                    state_next_s = ST_BOOT;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_BOOT: state_next_s = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_next_s = (DUMP_COUNT == 0) ? ST_DONE : ST_DUMP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DUMP: begin
                if (dump_hs_s && dump_last_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DUMP;
                end
            end
            ST_DONE: state_next_s = ST_DONE;
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State register; reset from any state lands back in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered control outputs, load pointer and dump sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_ptr_r   <= '0;
            dump_idx_r   <= '0;
            host_ready_r <= 1'b0;
            cpu_reset_r  <= 1'b1;
            dump_valid_r <= 1'b0;
            dump_addr_r  <= '0;
            dump_data_r  <= '0;
            dump_last_r  <= 1'b0;
        end else begin
            host_ready_r <= (state_next_s == ST_LOAD);
            // CPU is held in reset everywhere except RUN, so BOOT is its single reset cycle.
            cpu_reset_r  <= (state_next_s != ST_RUN);
            if (load_hs_s) begin
                load_ptr_r <= load_ptr_r + (AW+1)'(1);
            end
            if (state_r != ST_DUMP) begin
                dump_idx_r   <= '0;
                dump_valid_r <= 1'b0;
                dump_last_r  <= 1'b0;
            end else if (dump_present_s) begin
                // No stores happen in DUMP, so reading the array here is coherent.
                dump_valid_r <= 1'b1;
                dump_addr_r  <= dump_next_addr_s;
                dump_data_r  <= mem_r[dump_next_addr_s];
                dump_last_r  <= dump_is_last_s;
                dump_idx_r   <= dump_idx_r + CW'(1);
            end else if (dump_hs_s) begin
                dump_valid_r <= 1'b0;
                dump_last_r  <= 1'b0;
            end
        end
    end

    // Single write port: host loads in LOAD, CPU stores in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = data_addr;
        mem_wdata_s = mem_data_in;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (load_hs_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = load_ptr_r[AW-1:0];
            mem_wdata_s = host_data;
        end else if (store_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed-plus-random bench for mem_responder (DUMP_START=510, DUMP_COUNT=4).
// A plain array models the RAM; the expected dump sequence is derived from it.
module tb_mem_responder;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int DEPTH = 512;
    localparam int DSTART = 510;
    localparam int DCOUNT = 4;

    logic          clk;
    logic          reset;
    logic          host_valid;
    logic          host_ready;
    logic [DW-1:0] host_data;
    logic          host_last;
    logic          cpu_reset;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_next;
    logic [AW-1:0] data_addr;
    logic          mem_write;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          halt;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_last;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [0:DEPTH-1];
    bit            known     [0:DEPTH-1];

    mem_responder #(
        .AW(AW), .DW(DW), .DUMP_START(DSTART), .DUMP_COUNT(DCOUNT)
    ) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_last(host_last),
        .cpu_reset(cpu_reset),
        .inst_addr(inst_addr), .inst_next(inst_next),
        .data_addr(data_addr), .mem_write(mem_write),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .halt(halt),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        logic [DW-1:0] words [3];
        int a, b, idx, cyc, exp_addr;
        bit hs;

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        reset = 1'b1; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
        inst_addr = '0; data_addr = '0; mem_write = 1'b0; mem_data_in = '0;
        halt = 1'b0; dump_ready = 1'b0;
        step(); step();

        // Reset state
        check("rst_host_ready", host_ready, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_addr", dump_addr, 0);
        check("rst_dump_data", dump_data, 0);
        check("rst_dump_last", dump_last, 0);

        reset = 1'b0;
        step();
        check("load_ready_up", host_ready, 1);

        // Three-word load with two-cycle gaps and junk data while idle
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        for (int w = 0; w < 3; w++) begin
            host_valid = 1'b1; host_data = words[w]; host_last = (w == 2);
            check("load_ready", host_ready, 1);
            step();
            model_mem[w] = words[w]; known[w] = 1'b1;
            host_valid = 1'b0; host_last = 1'b0;
            if (w == 2) break;
            for (int g = 0; g < 2; g++) begin
                host_data = 16'($urandom);
                step();
            end
        end
        check("boot_ready_low", host_ready, 0);
        check("boot_cpu_reset", cpu_reset, 1);
        step();
        check("run_cpu_reset", cpu_reset, 0);

        for (int k = 0; k < 3; k++) begin
            inst_addr = 9'(2 - k); data_addr = 9'(k);
            #1;
            check("load_inst", inst_next, model_mem[2 - k]);
            check("load_data", mem_data_out, model_mem[k]);
        end

        // host traffic in RUN is ignored
        host_valid = 1'b1; host_data = 16'($urandom);
        check("run_ready_low", host_ready, 0);
        step();
        host_valid = 1'b0;
        inst_addr = 9'd0;
        #1;
        check("run_host_ignored", inst_next, model_mem[0]);

        // Store to 5: old value until the edge, new after
        d = 16'($urandom);
        data_addr = 9'd5; mem_data_in = d; mem_write = 1'b1;
        step();
        model_mem[5] = d; known[5] = 1'b1;
        mem_data_in = 16'hBEEF; inst_addr = 9'd5;
        #1;
        check("st_old_value", mem_data_out, model_mem[5]);
        check("st_old_fetch", inst_next, model_mem[5]);
        step();
        model_mem[5] = 16'hBEEF;
        mem_write = 1'b0;
        #1;
        check("st_new_value", mem_data_out, 16'hBEEF);
        check("st_new_fetch", inst_next, 16'hBEEF);

        // Random loads/stores, occasionally with fetch and data on the same word
        for (int it = 0; it < 40; it++) begin
            a = $urandom_range(0, 15);
            b = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, 15);
            data_addr = 9'(a); inst_addr = 9'(b);
            mem_write = 1'($urandom_range(0, 1));
            mem_data_in = 16'($urandom);
            #1;
            if (known[a]) check("rnd_data", mem_data_out, model_mem[a]);
            if (known[b]) check("rnd_inst", inst_next, model_mem[b]);
            step();
            if (mem_write) begin
                model_mem[a] = mem_data_in; known[a] = 1'b1;
            end
        end

        // Seed the dump window 510,511,0,1 (the store on 1 rides the halt edge)
        for (int k = 0; k < 2; k++) begin
            data_addr = 9'(510 + k); mem_data_in = 16'($urandom); mem_write = 1'b1;
            step();
            model_mem[510 + k] = mem_data_in; known[510 + k] = 1'b1;
        end
        data_addr = 9'd1; mem_data_in = 16'($urandom); halt = 1'b1;
        step();
        model_mem[1] = mem_data_in;
        halt = 1'b0;
        check("dump_entry_valid", dump_valid, 0);
        check("dump_cpu_reset", cpu_reset, 1);

        // Stores during DUMP must be ignored
        mem_write = 1'b1; data_addr = 9'd0; mem_data_in = ~model_mem[0];
        step();

        idx = 0; cyc = 0;
        while (idx < DCOUNT && cyc < 200) begin
            exp_addr = (DSTART + idx) % DEPTH;
            check("dump_valid", dump_valid, 1);
            check("dump_addr", dump_addr, exp_addr);
            check("dump_data", dump_data, model_mem[exp_addr]);
            check("dump_last", dump_last, (idx == DCOUNT - 1) ? 1 : 0);
            dump_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            data_addr = ($urandom_range(0, 1) == 1) ? 9'd0 : 9'd510;
            mem_data_in = 16'($urandom);
            hs = dump_valid && dump_ready;
            step();
            if (hs) idx++;
            cyc++;
        end
        check("dump_words", idx, DCOUNT);
        dump_ready = 1'b0; mem_write = 1'b0;
        check("done_valid", dump_valid, 0);
        check("done_cpu_reset", cpu_reset, 1);
        step(); step();
        check("done_stays", dump_valid, 0);
        inst_addr = 9'd0; data_addr = 9'd510;
        #1;
        check("dump_store_ignored0", inst_next, model_mem[0]);
        check("dump_store_ignored510", mem_data_out, model_mem[510]);

        // Full-depth load without host_last
        reset = 1'b1;
        step();
        check("rst2_dump_valid", dump_valid, 0);
        reset = 1'b0;
        step();
        for (int w = 0; w < DEPTH; w++) begin
            if ($urandom_range(0, 7) == 0) begin
                host_valid = 1'b0; host_data = 16'($urandom);
                step();
            end
            d = 16'($urandom);
            host_valid = 1'b1; host_data = d; host_last = 1'b0;
            check("full_ready", host_ready, 1);
            step();
            model_mem[w] = d; known[w] = 1'b1;
        end
        host_valid = 1'b0;
        check("full_boot_ready", host_ready, 0);
        check("full_boot_cpu_reset", cpu_reset, 1);
        step();
        check("full_run_cpu_reset", cpu_reset, 0);
        for (int k = 0; k < 16; k++) begin
            a = (k == 0) ? 511 : ((k == 1) ? 0 : $urandom_range(0, DEPTH - 1));
            b = $urandom_range(0, DEPTH - 1);
            inst_addr = 9'(a); data_addr = 9'(b);
            #1;
            check("full_inst", inst_next, model_mem[a]);
            check("full_data", mem_data_out, model_mem[b]);
        end

        // Reset in the middle of a dump
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        check("mid_dump_valid", dump_valid, 1);
        check("mid_dump_addr", dump_addr, DSTART);
        step();
        reset = 1'b1;
        step();
        check("mid_rst_valid", dump_valid, 0);
        reset = 1'b0;
        step();
        check("mid_rst_ready", host_ready, 1);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_valid2", dump_valid, 0);
        inst_addr = 9'd0;
        #1;
        check("ram_kept", inst_next, model_mem[0]);

        // Load pointer restarts at 0 after reset
        d = ~model_mem[0];
        host_valid = 1'b1; host_data = d; host_last = 1'b1;
        step();
        model_mem[0] = d;
        host_valid = 1'b0; host_last = 1'b0;
        inst_addr = 9'd0; data_addr = 9'd1;
        #1;
        check("reload_addr0", inst_next, model_mem[0]);
        check("reload_addr1", mem_data_out, model_mem[1]);
        check("reload_boot_ready", host_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
